// File: rtl/instr_mem_sync_pkg.sv
// Shared definitions for the synchronous instruction memory: FSM encoding,
// default NOP word and the index-width helper.
package instr_mem_sync_pkg;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Ceiling log2 for sizing the word index; depth is assumed to be >= 2.
  function automatic int clog2_f(input int value);
    logic [31:0] v;
    int          r;
    v = 32'(value - 1);
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/instr_mem_sync_ram.sv
// Single-port-style RAM: one synchronous write port and one registered
// read-first read port (a same-edge write is not visible to the read).
import instr_mem_sync_pkg::*;

module instr_mem_sync_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write and read in one process so the read samples the pre-write word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_sync.sv
// IF-stage instruction memory: registered fetch with stall hold, flush-to-NOP,
// misalignment flag, run-time loader port and optional clear-after-reset.
import instr_mem_sync_pkg::*;

module instr_mem_sync #(
  parameter int                 DATA_W         = 32,
  parameter int                 DEPTH          = 256,
  parameter logic [DATA_W-1:0]  NOP_WORD       = DATA_W'(NOP_WORD_DEF),
  parameter bit                 CLEAR_ON_RESET = 1'b1,
  localparam int                IDX_W          = clog2_f(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       fetch_addr,
  input  logic              fetch_req,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              misalign_flt,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ready
);

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [IDX_W-1:0]  r_clr_cnt;
  logic              r_valid;
  logic              r_misalign;
  logic              r_use_ram;
  logic              w_run;
  logic              w_clr_we;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_re;
  logic [DATA_W-1:0] w_rdata;
  logic [IDX_W-1:0]  w_fetch_idx;
  logic              w_misalign;
  logic              w_unused_addr;

  // Upper PC bits alias onto the array (index wraps modulo DEPTH).
  assign w_fetch_idx   = fetch_addr[IDX_W+1:2];
  assign w_misalign    = |fetch_addr[1:0];
  assign w_unused_addr = ^fetch_addr[31:IDX_W+2];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic: CLEAR leaves once the last word has been written.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_cnt == IDX_W'(DEPTH - 1)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = RESET_STATE;
    endcase
  end

  // FSM outputs; reset suppresses the clear write so reset never touches the array.
  always_comb begin
    w_run    = (r_state == ST_RUN);
    w_clr_we = (r_state == ST_CLEAR) && !reset;
    ready    = w_run;
  end

  // Clear counter walks the array once per CLEAR pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_cnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + IDX_W'(1);
    end else begin
      r_clr_cnt <= r_clr_cnt;
    end
  end

  // Write-source mux (clear sequencer vs loader) and read enable.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = ld_idx;
    w_wdata = ld_data;
    if (w_clr_we) begin
      w_we    = 1'b1;
      w_waddr = r_clr_cnt;
      w_wdata = NOP_WORD;
    end else begin
      w_we    = !reset && w_run && ld_en;
    end
    w_re = !reset && w_run && fetch_req && !flush && !stall && !w_misalign;
  end

  instr_mem_sync_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_fetch_idx),
    .o_rdata (w_rdata)
  );

  // Fetch output control: flush beats stall beats fetch.
  always_ff @(posedge clk) begin
    if (reset || !w_run || flush) begin
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_use_ram  <= 1'b0;
    end else if (stall) begin
      r_valid    <= r_valid;
      r_misalign <= r_misalign;
      r_use_ram  <= r_use_ram;
    end else if (fetch_req) begin
      r_valid    <= 1'b1;
      r_misalign <= w_misalign;
      r_use_ram  <= !w_misalign;
    end else begin
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_use_ram  <= 1'b0;
    end
  end

  assign instr        = r_use_ram ? w_rdata : NOP_WORD;
  assign instr_valid  = r_valid;
  assign misalign_flt = r_misalign;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed, table-driven bench for instr_mem_sync (DEPTH=256, clear on reset).
module tb_instr_mem_sync;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_addr;
  logic        fetch_req;
  logic        stall;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign_flt;
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_data;
  logic        ready;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        fetch_req;
    logic [31:0] addr;
    logic        stall;
    logic        flush;
    logic        ld_en;
    logic [7:0]  ld_idx;
    logic [31:0] ld_data;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  instr_mem_sync #(
    .DATA_W         (32),
    .DEPTH          (256),
    .NOP_WORD       (32'h0000_0000),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_addr   (fetch_addr),
    .fetch_req    (fetch_req),
    .stall        (stall),
    .flush        (flush),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .misalign_flt (misalign_flt),
    .ld_en        (ld_en),
    .ld_idx       (ld_idx),
    .ld_data      (ld_data),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fr, input logic [31:0] a, input logic st,
                              input logic fl, input logic le, input logic [7:0] li,
                              input logic [31:0] ld, input logic [31:0] ei,
                              input logic ev, input logic em);
    vec_t v;
    v.fetch_req = fr; v.addr = a; v.stall = st; v.flush = fl;
    v.ld_en = le; v.ld_idx = li; v.ld_data = ld;
    v.exp_instr = ei; v.exp_valid = ev; v.exp_mis = em;
    return v;
  endfunction

  task automatic idle_inputs();
    fetch_req = 1'b0; fetch_addr = 32'h0; stall = 1'b0; flush = 1'b0;
    ld_en = 1'b0; ld_idx = 8'h0; ld_data = 32'h0;
  endtask

  // Counts cycles until ready rises, bounded.
  task automatic wait_ready(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (!ready && n < 400) begin
      step();
      n++;
    end
    chk(name, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_mis",   {31'h0, misalign_flt}, 32'h0);

    // T1: clear lasts exactly DEPTH cycles
    wait_ready("t1_clear_len", 256);

    // fr addr st fl le idx data | instr valid mis
    vecs.push_back(mk(1'b1, 32'h0000_03FC, 1'b0, 1'b0, 1'b0, 8'd0,  32'h0,         NOP,           1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 8'd0,  32'h0000_8021, NOP,           1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 8'd1,  32'h0000_8821, NOP,           1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 8'd2,  32'h8E12_0000, NOP,           1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 8'd0,  32'h0,         32'h0000_8021, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 8'd0,  32'h0,         32'h0000_8821, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 8'd0,  32'h0,         32'h8E12_0000, 1'b1, 1'b0));
    // T3: stall hold, then flush wins over stall
    vecs.push_back(mk(1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 8'd0,  32'h0,         32'h0000_8821, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 8'd0,  32'h0,         32'h0000_8821, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'd0,  32'h0,         32'h0000_8821, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 8'd0,  32'h0,         32'h0000_8821, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 8'd0,  32'h0,         NOP,           1'b0, 1'b0));
    // T4: misaligned fetch, held by stall, cleared by aligned fetch
    vecs.push_back(mk(1'b1, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 8'd0,  32'h0,         NOP,           1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'd0,  32'h0,         NOP,           1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 8'd0,  32'h0,         32'h0000_8021, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 8'd0,  32'h0,         NOP,           1'b0, 1'b0));
    // T5: read-first, refetch, aliasing
    vecs.push_back(mk(1'b1, 32'h0000_0014, 1'b0, 1'b0, 1'b1, 8'd5,  32'hDEAD_BEEF, NOP,           1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0014, 1'b0, 1'b0, 1'b0, 8'd0,  32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0040_0014, 1'b0, 1'b0, 1'b0, 8'd0,  32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 8'd52, 32'h1234_5678, NOP,           1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0040_00D0, 1'b0, 1'b0, 1'b0, 8'd0,  32'h0,         32'h1234_5678, 1'b1, 1'b0));
    // loader write proceeds during flush
    vecs.push_back(mk(1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 8'd3,  32'hCAFE_F00D, NOP,           1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 8'd0,  32'h0,         32'hCAFE_F00D, 1'b1, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      fetch_req  = vecs[i].fetch_req;
      fetch_addr = vecs[i].addr;
      stall      = vecs[i].stall;
      flush      = vecs[i].flush;
      ld_en      = vecs[i].ld_en;
      ld_idx     = vecs[i].ld_idx;
      ld_data    = vecs[i].ld_data;
      step();
      chk($sformatf("v%0d_instr", i), instr, vecs[i].exp_instr);
      chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].exp_valid});
      chk($sformatf("v%0d_mis", i),   {31'h0, misalign_flt}, {31'h0, vecs[i].exp_mis});
    end
    idle_inputs();
    step();

    // T6: reset mid-CLEAR restarts the full pass; loader and fetch ignored in CLEAR
    reset = 1'b1;
    step();
    reset = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h0000_0014;
    ld_en = 1'b1; ld_idx = 8'd5; ld_data = 32'h0000_0055;
    for (int i = 0; i < 100; i++) begin
      step();
    end
    chk("t6_clr_ready", {31'h0, ready}, 32'h0);
    chk("t6_clr_valid", {31'h0, instr_valid}, 32'h0);
    chk("t6_clr_instr", instr, NOP);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_ready", {31'h0, ready}, 32'h0);
    ld_idx = 8'd200; ld_data = 32'h0000_00AA;
    wait_ready("t6_clear_len", 256);
    idle_inputs();
    fetch_req = 1'b1; fetch_addr = 32'h0000_0014;
    step();
    chk("t6_idx5_instr", instr, NOP);
    chk("t6_idx5_valid", {31'h0, instr_valid}, 32'h1);
    fetch_addr = 32'h0000_0320;
    step();
    chk("t6_idx200_instr", instr, NOP);
    fetch_addr = 32'h0000_0000;
    step();
    chk("t6_idx0_instr", instr, NOP);
    idle_inputs();
    step();
    chk("t6_idle_valid", {31'h0, instr_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
